// File: rtl/led_blink_pkg.sv
// Shared definitions for the multi-channel LED blinker: mode codes, channel
// FSM states and the rate-select to half-period divisor mapping.
package led_blink_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [2:0] {
    S_OFF,
    S_ON,
    S_BLINK,
    S_BURST,
    S_DONE
  } state_t;

  // Half-period length in clocks; never returns 0 so tiny clocks still toggle.
  function automatic int unsigned div_for(input int unsigned clk_hz,
                                          input logic [1:0]  rate_sel);
    int unsigned f_hz;
    int unsigned div;
    case (rate_sel)
      2'd0:    f_hz = 100;
      2'd1:    f_hz = 50;
      2'd2:    f_hz = 10;
      default: f_hz = 1;
    endcase
    div = clk_hz / (2 * f_hz);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: OFF/ON/BLINK/BURST behaviour with a rate select that is
// latched on mode entry and re-latched only at each half-period wrap.
module led_blink_channel
  import led_blink_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 25000,
  parameter int unsigned BURST_LEN = 3
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic [1:0] i_mode,
  input  logic [1:0] i_rate_sel,
  output logic       o_led_drive,
  output logic       o_burst_done
);

  localparam int unsigned DIV_MAX = div_for(CLK_HZ, 2'd3);
  localparam int unsigned CW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int unsigned BCW     = $clog2(BURST_LEN + 1);

  localparam logic [CW-1:0] LAST0 = CW'(div_for(CLK_HZ, 2'd0) - 1);
  localparam logic [CW-1:0] LAST1 = CW'(div_for(CLK_HZ, 2'd1) - 1);
  localparam logic [CW-1:0] LAST2 = CW'(div_for(CLK_HZ, 2'd2) - 1);
  localparam logic [CW-1:0] LAST3 = CW'(div_for(CLK_HZ, 2'd3) - 1);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_drive, w_drive_nxt;
  logic [BCW-1:0]   r_bcnt, w_bcnt_nxt;
  logic [1:0]       r_rate, w_rate_nxt;
  logic             r_done;
  logic [1:0]       w_cur_mode;
  logic [CW-1:0]    w_last;
  logic             w_wrap;

  always_comb begin
    w_cur_mode = MODE_OFF;
    case (r_state)
      S_ON:            w_cur_mode = MODE_ON;
      S_BLINK:         w_cur_mode = MODE_BLINK;
      S_BURST, S_DONE: w_cur_mode = MODE_BURST;
      default:         w_cur_mode = MODE_OFF;
    endcase
  end

  always_comb begin
    w_last = LAST3;
    case (r_rate)
      2'd0:    w_last = LAST0;
      2'd1:    w_last = LAST1;
      2'd2:    w_last = LAST2;
      default: w_last = LAST3;
    endcase
  end

  assign w_wrap = (r_cnt == w_last);

  // A mode differing from the current state's mode class is a fresh entry;
  // S_DONE belongs to the BURST class so it is left only by a real mode change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drive_nxt = r_drive;
    w_bcnt_nxt  = r_bcnt;
    w_rate_nxt  = r_rate;
    if (i_mode != w_cur_mode) begin
      w_cnt_nxt   = '0;
      w_drive_nxt = (i_mode == MODE_ON);
      w_bcnt_nxt  = '0;
      w_rate_nxt  = i_rate_sel;
      case (i_mode)
        MODE_ON:    w_state_nxt = S_ON;
        MODE_BLINK: w_state_nxt = S_BLINK;
        MODE_BURST: w_state_nxt = S_BURST;
        default:    w_state_nxt = S_OFF;
      endcase
    end else if (r_state == S_BLINK || r_state == S_BURST) begin
      if (w_wrap) begin
        w_cnt_nxt   = '0;
        w_rate_nxt  = i_rate_sel;
        w_drive_nxt = ~r_drive;
        if (r_state == S_BURST && r_drive) begin
          if (r_bcnt == BCW'(BURST_LEN - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
          end
        end
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
      r_drive <= 1'b0;
      r_bcnt  <= '0;
      r_rate  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drive <= w_drive_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_rate  <= w_rate_nxt;
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign o_led_drive  = r_drive;
  assign o_burst_done = r_done;

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker: slices the packed mode/rate buses, applies the
// global enable and instantiates one independent channel per LED.
module led_blink_multi
  import led_blink_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CLK_HZ    = 25000,
  parameter int unsigned BURST_LEN = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic [2*NUM_CH-1:0]   i_mode,
  input  logic [2*NUM_CH-1:0]   i_rate_sel,
  output logic [NUM_CH-1:0]     o_led_drive,
  output logic [NUM_CH-1:0]     o_burst_done
);

  logic [2*NUM_CH-1:0] w_mode;

  // Disabled channels see OFF, so re-enabling is an ordinary mode entry.
  assign w_mode = i_enable ? i_mode : {NUM_CH{MODE_OFF}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_blink_channel #(
      .CLK_HZ    (CLK_HZ),
      .BURST_LEN (BURST_LEN)
    ) u_ch (
      .i_clock      (i_clock),
      .i_reset_n    (i_reset_n),
      .i_mode       (w_mode[2*g +: 2]),
      .i_rate_sel   (i_rate_sel[2*g +: 2]),
      .o_led_drive  (o_led_drive[g]),
      .o_burst_done (o_burst_done[g])
    );
  end

endmodule
